uart_tx_cfg: RTL

Runtime-configurable UART transmitter and the successor of the fixed 8N1 byte transmitter. Serialises one word per valid/ready handshake. Supports a programmable divisor, data length 1..MAX_DATA_W, none/even/odd parity, and 1 or 2 stop bits. It sits between the host-side command/bridge logic (e.g. the UART2I2C response path) and the tx pin.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_baud_gen.sv | 17 +
 rtl/uart_tx_cfg.sv | 98 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings for the configurable UART transmitter and receiver
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE = 2'b00, PAR_EVEN = 2'b01, PAR_ODD = 2'b10, PAR_RSVD = 2'b11} parity_e;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter, ticks once every div+1 enabled cycles
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             bit_tick
);
  logic [DIV_W-1:0] cnt;
  assign bit_tick = enable && !clear && cnt == div;
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) cnt <= '0;
    else cnt <= (clear || bit_tick) ? '0 : enable ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter (divisor, length, parity, stop bits)
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int MAX_DATA_W = 8,
  parameter int DIV_W      = 16,
  parameter int LEN_W      = 4
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [MAX_DATA_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DIV_W-1:0]      baud_div,
  input  logic [LEN_W-1:0]      data_len,
  input  logic [1:0]            parity_mode,
  input  logic                  stop_bits,
  output logic                  uart_tx,
  output logic                  tx_done,
  output logic                  busy
);
  uart_state_e           state;
  logic [MAX_DATA_W-1:0] sh;
  logic [LEN_W-1:0]      len_q, len_c, bit_cnt;
  logic [DIV_W-1:0]      div_q, div_c;
  logic                  par_en, par_bit, par_c, two_stop, accept, bit_tick;
  assign tx_ready = state == IDLE;
  assign busy     = !tx_ready;
  assign accept   = tx_valid && tx_ready;
  assign div_c    = baud_div == '0 ? DIV_W'(1) : baud_div;
  assign len_c    = (data_len == '0 || data_len > LEN_W'(MAX_DATA_W)) ? LEN_W'(MAX_DATA_W) : data_len;
  // parity covers only the bits that will actually be sent
  assign par_c    = ^(tx_data & ~({MAX_DATA_W{1'b1}} << len_c)) ^ (parity_mode == PAR_ODD);
  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .clear(accept),
    .enable(busy),
    .div(div_q),
    .bit_tick(bit_tick)
  );
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      state    <= IDLE;
      uart_tx  <= IDLE_LEVEL;
      tx_done  <= 1'b0;
      sh       <= '0;
      len_q    <= '0;
      div_q    <= DIV_W'(1);
      bit_cnt  <= '0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      two_stop <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: if (tx_valid) begin
          state    <= START;
          uart_tx  <= START_BIT;
          sh       <= tx_data;
          len_q    <= len_c;
          div_q    <= div_c;
          par_en   <= parity_mode == PAR_EVEN || parity_mode == PAR_ODD;
          par_bit  <= par_c;
          two_stop <= stop_bits;
        end
        START: if (bit_tick) begin
          state   <= DATA;
          uart_tx <= sh[0];
          sh      <= sh >> 1;
          bit_cnt <= '0;
        end
        DATA: if (bit_tick) begin
          if (bit_cnt == len_q - 1'b1) begin
            state   <= par_en ? PARITY : STOP;
            uart_tx <= par_en ? par_bit : STOP_BIT;
            bit_cnt <= '0;
          end else begin
            uart_tx <= sh[0];
            sh      <= sh >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARITY: if (bit_tick) begin
          state   <= STOP;
          uart_tx <= STOP_BIT;
        end
        STOP: if (bit_tick) begin
          if (two_stop && bit_cnt == '0) bit_cnt <= LEN_W'(1);
          else begin
            state   <= IDLE;
            tx_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
